// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//   Four-digit BCD stopwatch core showing SS.hh: tens of seconds, seconds,
//   tenths and hundredths. It sits between the debounced key-pulse logic and
//   the 7-segment display driver.
//   One key toggles start/pause, and the other key clears the count.
//   An internal prescaler divides clk down to the hundredth-second tick.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   key_ps_en      in   1  start/pause request (debounced, active-high level)
//   key_rst_en     in   1  clear request (debounced, active-high level)
//   numcount4_out  out  4  BCD tens of seconds
//   numcount3_out  out  4  BCD seconds
//   numcount2_out  out  4  BCD tenths
//   numcount1_out  out  4  BCD hundredths
//
// States
//   state | meaning
//   ------+--------------------------------------------------
//   STOP  | digits and prescaler hold (pause keeps partial count)
//   RUN   | prescaler advances, and digits step on every tick
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_ps_en,
  input  logic       key_rst_en,
  output logic [3:0] numcount4_out,
  output logic [3:0] numcount3_out,
  output logic [3:0] numcount2_out,
  output logic [3:0] numcount1_out
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_TC  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ps_prev;
  logic             r_rst_prev;
  logic [CNT_W-1:0] r_presc;
  logic [3:0]       r_d1, r_d2, r_d3, r_d4;
  logic [3:0]       w_n1, w_n2, w_n3, w_n4;
  logic             w_ps_edge;
  logic             w_rst_edge;
  logic             w_tick;
  logic             w_c1, w_c2, w_c3;

  // Edges act on the same clk edge that first samples the key high.
  assign w_ps_edge  = key_ps_en  & ~r_ps_prev;
  assign w_rst_edge = key_rst_en & ~r_rst_prev;
  assign w_tick     = (r_state == RUN) && (r_presc == LP_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ps_prev  <= 1'b0;
      r_rst_prev <= 1'b0;
    end else begin
      r_ps_prev  <= key_ps_en;
      r_rst_prev <= key_rst_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= STOP;
    else        r_state <= w_state_nxt;
  end

  // A clear takes priority over a simultaneous start/pause edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_rst_edge) begin
      w_state_nxt = STOP;
    end else if (w_ps_edge) begin
      case (r_state)
        STOP:    w_state_nxt = RUN;
        RUN:     w_state_nxt = STOP;
        default: w_state_nxt = STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_rst_edge) begin
      r_presc <= '0;
    end else if (r_state == RUN) begin
      r_presc <= w_tick ? '0 : r_presc + LP_ONE;
    end
  end

  // Ripple carry through the digits. Any out-of-range code is forced to 0.
  assign w_c1 = w_tick && (r_d1 == 4'd9);
  assign w_c2 = w_c1   && (r_d2 == 4'd9);
  assign w_c3 = w_c2   && (r_d3 == 4'd9);

  always_comb begin
    w_n1 = (r_d1 > 4'd9) ? 4'd0 : r_d1;
    w_n2 = (r_d2 > 4'd9) ? 4'd0 : r_d2;
    w_n3 = (r_d3 > 4'd9) ? 4'd0 : r_d3;
    w_n4 = (r_d4 > 4'd9) ? 4'd0 : r_d4;
    if (w_tick && r_d1 <= 4'd9) w_n1 = (r_d1 == 4'd9) ? 4'd0 : r_d1 + 4'd1;
    if (w_c1   && r_d2 <= 4'd9) w_n2 = (r_d2 == 4'd9) ? 4'd0 : r_d2 + 4'd1;
    if (w_c2   && r_d3 <= 4'd9) w_n3 = (r_d3 == 4'd9) ? 4'd0 : r_d3 + 4'd1;
    if (w_c3   && r_d4 <= 4'd9) w_n4 = (r_d4 == 4'd9) ? 4'd0 : r_d4 + 4'd1;
    if (w_rst_edge) begin
      w_n1 = 4'd0;
      w_n2 = 4'd0;
      w_n3 = 4'd0;
      w_n4 = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= 4'd0;
      r_d2 <= 4'd0;
      r_d3 <= 4'd0;
      r_d4 <= 4'd0;
    end else begin
      r_d1 <= w_n1;
      r_d2 <= w_n2;
      r_d3 <= w_n3;
      r_d4 <= w_n4;
    end
  end

  assign numcount1_out = r_d1;
  assign numcount2_out = r_d2;
  assign numcount3_out = r_d3;
  assign numcount4_out = r_d4;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       a_ps, a_rst, b_ps, b_rst;
  logic [3:0] a4, a3, a2, a1;
  logic [3:0] b4, b3, b2, b1;
  int         n_vec;
  int         n_err;

  // a: normal rate (10 clk per tick); b: one tick per clk for fast wrap tests
  stopwatch_counter #(.TICK_DIV(10), .CNT_W(20)) u_a (
    .clk(clk), .rst_n(rst_n), .key_ps_en(a_ps), .key_rst_en(a_rst),
    .numcount4_out(a4), .numcount3_out(a3), .numcount2_out(a2), .numcount1_out(a1));

  stopwatch_counter #(.TICK_DIV(1), .CNT_W(20)) u_b (
    .clk(clk), .rst_n(rst_n), .key_ps_en(b_ps), .key_rst_en(b_rst),
    .numcount4_out(b4), .numcount3_out(b3), .numcount2_out(b2), .numcount1_out(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_ps = 1'b0; a_rst = 1'b0; b_ps = 1'b0; b_rst = 1'b0;

    // T1 reset
    #23 rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 50; i++) begin
      check("t1_reset_a", {a4, a3, a2, a1}, 16'h0000);
      cyc(1);
    end
    check("t1_reset_b", {b4, b3, b2, b1}, 16'h0000);

    // T2 start: 1-clk pulse, then 1000 clks gives 100 ticks
    a_ps = 1'b1; cyc(1); a_ps = 1'b0;
    cyc(9);
    check("t2_pre_first_tick", {a4, a3, a2, a1}, 16'h0000);
    cyc(1);
    check("t2_first_tick", {a4, a3, a2, a1}, 16'h0001);
    cyc(989);
    check("t2_999", {a4, a3, a2, a1}, 16'h0099);
    cyc(1);
    check("t2_1000", {a4, a3, a2, a1}, 16'h0100);

    // Clear alone while running
    a_rst = 1'b1; cyc(1); a_rst = 1'b0;
    check("t2_clear", {a4, a3, a2, a1}, 16'h0000);
    cyc(30);
    check("t2_clear_stopped", {a4, a3, a2, a1}, 16'h0000);

    // T3 pause/resume: the pause edge itself still counts (106 counts before pause)
    a_ps = 1'b1; cyc(1); a_ps = 1'b0;
    cyc(105);
    check("t3_105", {a4, a3, a2, a1}, 16'h0010);
    a_ps = 1'b1; cyc(1); a_ps = 1'b0;
    cyc(200);
    check("t3_paused", {a4, a3, a2, a1}, 16'h0010);
    a_ps = 1'b1; cyc(1); a_ps = 1'b0;
    cyc(93);
    check("t3_resume_93", {a4, a3, a2, a1}, 16'h0019);
    cyc(2);
    check("t3_resume_95", {a4, a3, a2, a1}, 16'h0020);

    // T4 wrap on b
    b_ps = 1'b1; cyc(1); b_ps = 1'b0;
    cyc(9999);
    check("t4_9999", {b4, b3, b2, b1}, 16'h9999);
    cyc(1);
    check("t4_wrap", {b4, b3, b2, b1}, 16'h0000);
    cyc(1);
    check("t4_still_running", {b4, b3, b2, b1}, 16'h0001);

    // T5 clear with simultaneous start/pause at 12.34
    cyc(1233);
    check("t5_1234", {b4, b3, b2, b1}, 16'h1234);
    b_ps = 1'b1; b_rst = 1'b1; cyc(1); b_ps = 1'b0; b_rst = 1'b0;
    check("t5_cleared", {b4, b3, b2, b1}, 16'h0000);
    cyc(100);
    check("t5_stays_stopped", {b4, b3, b2, b1}, 16'h0000);

    // T6 held key: single toggle, 4 counts while held plus 20 after gives 2 ticks
    a_rst = 1'b1; cyc(1); a_rst = 1'b0;
    check("t6_clear", {a4, a3, a2, a1}, 16'h0000);
    a_ps = 1'b1; cyc(5); a_ps = 1'b0;
    cyc(20);
    check("t6_held_once", {a4, a3, a2, a1}, 16'h0002);
    cyc(76);
    check("t6_100_counts", {a4, a3, a2, a1}, 16'h0010);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_a", {a4, a3, a2, a1}, 16'h0000);
    #2 rst_n = 1'b1;
    cyc(30);
    check("t6_after_reset_stopped", {a4, a3, a2, a1}, 16'h0000);
    check("t6_after_reset_b", {b4, b3, b2, b1}, 16'h0000);

    // After reset, a single pulse starts again from a fresh prescaler
    a_ps = 1'b1; cyc(1); a_ps = 1'b0;
    cyc(10);
    check("t6_restart_tick", {a4, a3, a2, a1}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
